cpu_control_fsm: RTL and testbench

- Control unit that drives the 7-bit program counter (`Clr`/`Up`) and consumes the instruction word the instruction ROM returns at that address.
- Latches the instruction into an internal instruction register (IR) and decodes it.
- Sequences the data memory, register file and ALU controls for NOOP, LOAD, STORE, ADD, SUB and HALT.
- Sits between instruction ROM/PC and the datapath. It is the reader/consumer side of the PC address stream.

---
 rtl/cpu_control_fsm_if.sv | 29 ++
 rtl/cpu_control_fsm.sv | 154 +++++++++++++++
 tb/tb_cpu_control_fsm.sv | 135 +++++++++++++
 3 files changed

// File: rtl/cpu_control_fsm_if.sv
// Bus between the control FSM, the PC/instruction ROM and the datapath.
// The FSM is the master; the ROM/PC/datapath side is the slave.
interface cpu_control_fsm_if;
    logic [15:0] ROM_data;
    logic        PC_clr;
    logic        PC_up;
    logic [15:0] IR;
    logic [7:0]  D_addr;
    logic        D_wr;
    logic        RF_s;
    logic [3:0]  RF_W_addr;
    logic        RF_W_en;
    logic [3:0]  RF_Ra_addr;
    logic [3:0]  RF_Rb_addr;
    logic [2:0]  ALU_s0;
    logic [3:0]  state_out;

    modport master (
        input  ROM_data,
        output PC_clr, PC_up, IR, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
               RF_Ra_addr, RF_Rb_addr, ALU_s0, state_out
    );

    modport slave (
        output ROM_data,
        input  PC_clr, PC_up, IR, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
               RF_Ra_addr, RF_Rb_addr, ALU_s0, state_out
    );
endinterface

// File: rtl/cpu_control_fsm.sv
// Instruction fetch/decode/execute controller for a 16-bit single-issue CPU.
// Outputs are Moore; they are decoded from the next state/IR and registered.
module cpu_control_fsm #(
    parameter logic [2:0] ALU_PASS = 3'b000,
    parameter logic [2:0] ALU_ADD  = 3'b001,
    parameter logic [2:0] ALU_SUB  = 3'b010
) (
    input logic               Clock,
    input logic               Clr,
    cpu_control_fsm_if.master bus
);

    typedef enum logic [3:0] {
        ST_INIT   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_LOADA  = 4'd3,
        ST_LOADB  = 4'd4,
        ST_STORE  = 4'd5,
        ST_ADD    = 4'd6,
        ST_SUB    = 4'd7,
        ST_HALT   = 4'd8
    } state_t;

    localparam logic [3:0] OP_STORE = 4'h1;
    localparam logic [3:0] OP_LOAD  = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_HALT  = 4'h5;

    typedef struct packed {
        logic       pc_clr;
        logic       pc_up;
        logic [7:0] d_addr;
        logic       d_wr;
        logic       rf_s;
        logic [3:0] rf_w_addr;
        logic       rf_w_en;
        logic [3:0] rf_ra_addr;
        logic [3:0] rf_rb_addr;
        logic [2:0] alu_s0;
    } ctl_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [15:0] ir_r;
    logic [15:0] ir_nxt_s;
    ctl_t        ctl_r;
    ctl_t        ctl_nxt_s;

    function automatic ctl_t decode_ctl(input state_t st, input logic [15:0] ir);
        ctl_t c;
        c        = '0;
        c.alu_s0 = ALU_PASS;
        case (st)
            ST_INIT:  c.pc_clr = 1'b1;
            ST_FETCH: c.pc_up  = 1'b1;
            ST_DECODE: begin
                // Only address fields are presented here; enables wait for execute.
                case (ir[15:12])
                    OP_STORE: begin
                        c.d_addr     = ir[11:4];
                        c.rf_ra_addr = ir[3:0];
                    end
                    OP_LOAD: begin
                        c.d_addr    = ir[11:4];
                        c.rf_w_addr = ir[3:0];
                    end
                    OP_ADD, OP_SUB: begin
                        c.rf_ra_addr = ir[11:8];
                        c.rf_rb_addr = ir[7:4];
                        c.rf_w_addr  = ir[3:0];
                    end
                    default: c.d_addr = 8'h00;
                endcase
            end
            ST_LOADA, ST_LOADB: begin
                c.d_addr    = ir[11:4];
                c.rf_w_addr = ir[3:0];
                c.rf_s      = 1'b1;
                c.rf_w_en   = (st == ST_LOADB);
            end
            ST_STORE: begin
                c.d_addr     = ir[11:4];
                c.rf_ra_addr = ir[3:0];
                c.d_wr       = 1'b1;
            end
            ST_ADD, ST_SUB: begin
                c.rf_ra_addr = ir[11:8];
                c.rf_rb_addr = ir[7:4];
                c.rf_w_addr  = ir[3:0];
                c.rf_w_en    = 1'b1;
                c.alu_s0     = (st == ST_ADD) ? ALU_ADD : ALU_SUB;
            end
            default: c.pc_clr = 1'b0;
        endcase
        return c;
    endfunction

    // Next-state, next-IR and next-output decode.
    always_comb begin
        state_nxt_s = state_r;
        ir_nxt_s    = ir_r;
        case (state_r)
            ST_INIT:  state_nxt_s = ST_FETCH;
            ST_FETCH: begin
                state_nxt_s = ST_DECODE;
                ir_nxt_s    = bus.ROM_data;
            end
            ST_DECODE: begin
                case (ir_r[15:12])
                    OP_STORE: state_nxt_s = ST_STORE;
                    OP_LOAD:  state_nxt_s = ST_LOADA;
                    OP_ADD:   state_nxt_s = ST_ADD;
                    OP_SUB:   state_nxt_s = ST_SUB;
                    OP_HALT:  state_nxt_s = ST_HALT;
                    default:  state_nxt_s = ST_FETCH;
                endcase
            end
            ST_LOADA: state_nxt_s = ST_LOADB;
            ST_LOADB, ST_STORE, ST_ADD, ST_SUB: state_nxt_s = ST_FETCH;
            ST_HALT:  state_nxt_s = ST_HALT;
            default:  state_nxt_s = ST_INIT;
        endcase
        ctl_nxt_s = decode_ctl(state_nxt_s, ir_nxt_s);
    end

    // State, IR and output registers; Clr overrides every transition.
    always_ff @(posedge Clock) begin
        if (Clr) begin
            state_r <= ST_INIT;
            ir_r    <= 16'h0000;
            ctl_r   <= decode_ctl(ST_INIT, 16'h0000);
        end else begin
            state_r <= state_nxt_s;
            ir_r    <= ir_nxt_s;
            ctl_r   <= ctl_nxt_s;
        end
    end

    assign bus.PC_clr     = ctl_r.pc_clr;
    assign bus.PC_up      = ctl_r.pc_up;
    assign bus.IR         = ir_r;
    assign bus.D_addr     = ctl_r.d_addr;
    assign bus.D_wr       = ctl_r.d_wr;
    assign bus.RF_s       = ctl_r.rf_s;
    assign bus.RF_W_addr  = ctl_r.rf_w_addr;
    assign bus.RF_W_en    = ctl_r.rf_w_en;
    assign bus.RF_Ra_addr = ctl_r.rf_ra_addr;
    assign bus.RF_Rb_addr = ctl_r.rf_rb_addr;
    assign bus.ALU_s0     = ctl_r.alu_s0;
    assign bus.state_out  = state_r;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Scoreboard bench for cpu_control_fsm: per-cycle expected output vectors are
// queued per instruction and compared one per cycle on the falling edge.
module tb_cpu_control_fsm;

    logic Clock;
    logic Clr;
    int   n_checks;
    int   n_fail;
    logic [15:0] cur_ir;
    logic [47:0] sb_q[$];

    cpu_control_fsm_if bus ();

    cpu_control_fsm dut (
        .Clock (Clock),
        .Clr   (Clr),
        .bus   (bus.master)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // {state, PC_clr, PC_up, IR, D_addr, D_wr, RF_s, W_addr, W_en, Ra, Rb, ALU}
    function automatic logic [47:0] mk(
        input logic [3:0] st, input logic [15:0] ir, input logic pcc, input logic pcu,
        input logic [7:0] da, input logic dw, input logic rfs, input logic [3:0] wa,
        input logic we, input logic [3:0] ra, input logic [3:0] rb, input logic [2:0] alu);
        return {st, pcc, pcu, ir, da, dw, rfs, wa, we, ra, rb, alu};
    endfunction

    function automatic logic [47:0] observed();
        return {bus.state_out, bus.PC_clr, bus.PC_up, bus.IR, bus.D_addr, bus.D_wr,
                bus.RF_s, bus.RF_W_addr, bus.RF_W_en, bus.RF_Ra_addr, bus.RF_Rb_addr,
                bus.ALU_s0};
    endfunction

    task automatic check_eq(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (state got %0d exp %0d)",
                     tag, got, exp, got[47:44], exp[47:44]);
        end
    endtask

    // Called at a falling edge while the DUT sits in Fetch. keep>0 checks only
    // the first keep cycles and leaves the bench on that cycle.
    task automatic run_instr(input logic [15:0] word, input int keep);
        logic [3:0] op;
        int n;
        logic [47:0] e;
        op = word[15:12];
        sb_q.push_back(mk(4'd1, cur_ir, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 3'b000));
        case (op)
            4'h1: sb_q.push_back(mk(4'd2, word, 1'b0, 1'b0, word[11:4], 1'b0, 1'b0, 4'h0, 1'b0, word[3:0], 4'h0, 3'b000));
            4'h2: sb_q.push_back(mk(4'd2, word, 1'b0, 1'b0, word[11:4], 1'b0, 1'b0, word[3:0], 1'b0, 4'h0, 4'h0, 3'b000));
            4'h3, 4'h4: sb_q.push_back(mk(4'd2, word, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, word[3:0], 1'b0, word[11:8], word[7:4], 3'b000));
            default: sb_q.push_back(mk(4'd2, word, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 3'b000));
        endcase
        case (op)
            4'h1: sb_q.push_back(mk(4'd5, word, 1'b0, 1'b0, word[11:4], 1'b1, 1'b0, 4'h0, 1'b0, word[3:0], 4'h0, 3'b000));
            4'h2: begin
                sb_q.push_back(mk(4'd3, word, 1'b0, 1'b0, word[11:4], 1'b0, 1'b1, word[3:0], 1'b0, 4'h0, 4'h0, 3'b000));
                sb_q.push_back(mk(4'd4, word, 1'b0, 1'b0, word[11:4], 1'b0, 1'b1, word[3:0], 1'b1, 4'h0, 4'h0, 3'b000));
            end
            4'h3: sb_q.push_back(mk(4'd6, word, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, word[3:0], 1'b1, word[11:8], word[7:4], 3'b001));
            4'h4: sb_q.push_back(mk(4'd7, word, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, word[3:0], 1'b1, word[11:8], word[7:4], 3'b010));
            4'h5: for (int h = 0; h < 20; h++)
                sb_q.push_back(mk(4'd8, word, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 3'b000));
            default: ;
        endcase
        bus.ROM_data = word;
        n = (keep > 0) ? keep : sb_q.size();
        for (int k = 0; k < n; k++) begin
            if (k > 0) @(negedge Clock);
            e = sb_q.pop_front();
            check_eq($sformatf("instr_%h_c%0d", word, k), observed(), e);
        end
        if (keep > 0) begin
            sb_q.delete();
        end else begin
            @(negedge Clock);
            cur_ir = word;
        end
    endtask

    // Pulse Clr for one cycle from a falling edge; checks Init then Fetch.
    task automatic apply_clr(input string tag);
        Clr = 1'b1;
        sb_q.push_back(mk(4'd0, 16'h0000, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 3'b000));
        sb_q.push_back(mk(4'd1, 16'h0000, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 3'b000));
        @(negedge Clock);
        check_eq({tag, "_init"}, observed(), sb_q.pop_front());
        Clr = 1'b0;
        @(negedge Clock);
        check_eq({tag, "_fetch"}, observed(), sb_q.pop_front());
        cur_ir = 16'h0000;
    endtask

    initial begin
        logic [15:0] w;
        n_checks = 0;
        n_fail   = 0;
        cur_ir   = 16'h0000;
        Clr      = 1'b1;
        bus.ROM_data = 16'h0000;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        apply_clr("reset");

        run_instr(16'h3125, 0);
        run_instr(16'h21A3, 0);
        run_instr(16'h1FF7, 0);
        run_instr(16'h0000, 0);
        run_instr(16'hF123, 0);
        run_instr(16'h4ABC, 0);
        run_instr(16'h5000, 0);
        apply_clr("halt_clr");

        // Clr during LoadA: Fetch, Decode, LoadA checked, then cleared.
        run_instr(16'h21A3, 3);
        apply_clr("mid_load");

        // Mixed traffic past 128 fetches to cover PC wrap.
        for (int i = 0; i < 140; i++) begin
            w = 16'($urandom);
            if (w[15:12] == 4'h5) w[15:12] = 4'h3;
            run_instr(w, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
